// File: rtl/gate_access_arbiter.sv
// gate_access_arbiter
// Shares one code check and one door release among NUM_READERS card readers. A round-robin
// arbiter picks a requesting reader and latches its code. The code is range-checked for one
// cycle. A valid code holds the door open for OPEN_CYCLES cycles. An invalid code gives a
// one-cycle denied pulse.
//
// Optional feature: define GATE_ACCESS_LOCKOUT_EN to enable per-reader lockout. After
// LOCKOUT_FAILS consecutive denials, a reader is excluded from arbitration for
// LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   req        - per-reader request level, held until served
//   code_bus   - reader i code in bits [i*CODE_W +: CODE_W]
//   grant      - one-hot served reader, zero in IDLE
//   granted_id - index of the reader last granted
//   door_open  - door release, high only in OPEN
//   denied     - one-cycle pulse on a rejected code
//   state_out  - FSM state (IDLE=00, CHECK=01, OPEN=10, DENY=11)
//   locked     - per-reader lockout flags (zero without lockout)
module gate_access_arbiter #(
    parameter int unsigned NUM_READERS    = 4,
    parameter int unsigned CODE_W         = 4,
    parameter int unsigned CODE_MIN       = 4,
    parameter int unsigned CODE_MAX       = 11,
    parameter int unsigned OPEN_CYCLES    = 16,
    parameter int unsigned LOCKOUT_FAILS  = 3,
    parameter int unsigned LOCKOUT_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_READERS-1:0]        req,
    input  logic [NUM_READERS*CODE_W-1:0] code_bus,
    output logic [NUM_READERS-1:0]        grant,
    output logic [2:0]                    granted_id,
    output logic                          door_open,
    output logic                          denied,
    output logic [1:0]                    state_out,
    output logic [NUM_READERS-1:0]        locked
);

    localparam int unsigned HoldW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCheck = 2'b01,
        StOpen  = 2'b10,
        StDeny  = 2'b11
    } state_e;

    state_e                   state_q;
    logic [NUM_READERS-1:0]   grant_q;
    logic [2:0]               granted_id_q;
    logic [2:0]               ptr_q;
    logic [CODE_W-1:0]        code_q;
    logic [HoldW-1:0]         hold_q;
    logic                     door_open_q;
    logic                     denied_q;

    logic [NUM_READERS-1:0]   eligible;
    logic                     win_found;
    logic [2:0]               win_idx;
    logic [CODE_W-1:0]        win_code;
    logic                     code_ok;

    assign eligible = req & ~locked;

    // Search upward from ptr+1 with wrap; the first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= int'(NUM_READERS); k++) begin
            int unsigned j;
            j = (int'(ptr_q) + k) % NUM_READERS;
            if (!win_found && eligible[j]) begin
                win_found = 1'b1;
                win_idx   = 3'(j);
            end
        end
    end

    assign win_code = code_bus[int'(win_idx)*CODE_W +: CODE_W];
    assign code_ok  = (32'(code_q) >= CODE_MIN) && (32'(code_q) <= CODE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            granted_id_q <= '0;
            ptr_q        <= 3'(NUM_READERS - 1);
            code_q       <= '0;
            hold_q       <= '0;
            door_open_q  <= 1'b0;
            denied_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        granted_id_q <= win_idx;
                        ptr_q        <= win_idx;
                        code_q       <= win_code;
                        grant_q      <= {{(NUM_READERS-1){1'b0}}, 1'b1} << win_idx;
                        state_q      <= StCheck;
                    end
                end
                StCheck: begin
                    hold_q <= '0;
                    if (code_ok) begin
                        state_q     <= StOpen;
                        door_open_q <= 1'b1;
                    end else begin
                        state_q  <= StDeny;
                        denied_q <= 1'b1;
                    end
                end
                StOpen: begin
                    if (hold_q == HoldW'(OPEN_CYCLES - 1)) begin
                        state_q     <= StIdle;
                        door_open_q <= 1'b0;
                        grant_q     <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                StDeny: begin
                    state_q  <= StIdle;
                    denied_q <= 1'b0;
                    grant_q  <= '0;
                end
                default: begin
                    state_q     <= StIdle;
                    grant_q     <= '0;
                    door_open_q <= 1'b0;
                    denied_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_ACCESS_LOCKOUT_EN
    localparam int unsigned FailW = $clog2(LOCKOUT_FAILS + 1);
    localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);

    logic [FailW-1:0]       fail_cnt_q [NUM_READERS];
    logic [LockW-1:0]       lock_cnt_q [NUM_READERS];
    logic [NUM_READERS-1:0] locked_q;

    // The lock is set on the DENY edge, so it blocks arbitration from the following IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q <= '0;
            for (int i = 0; i < int'(NUM_READERS); i++) begin
                fail_cnt_q[i] <= '0;
                lock_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_READERS); i++) begin
                if (locked_q[i]) begin
                    if (lock_cnt_q[i] == LockW'(1)) begin
                        locked_q[i]   <= 1'b0;
                        lock_cnt_q[i] <= '0;
                        fail_cnt_q[i] <= '0;
                    end else begin
                        lock_cnt_q[i] <= lock_cnt_q[i] - 1'b1;
                    end
                end else if (state_q == StCheck && granted_id_q == 3'(i)) begin
                    if (code_ok) begin
                        fail_cnt_q[i] <= '0;
                    end else if (fail_cnt_q[i] < FailW'(LOCKOUT_FAILS)) begin
                        fail_cnt_q[i] <= fail_cnt_q[i] + 1'b1;
                    end
                end else if (state_q == StDeny && granted_id_q == 3'(i) &&
                             fail_cnt_q[i] == FailW'(LOCKOUT_FAILS)) begin
                    locked_q[i]   <= 1'b1;
                    lock_cnt_q[i] <= LockW'(LOCKOUT_CYCLES);
                end
            end
        end
    end

    assign locked = locked_q;
`else
    assign locked = '0;
`endif

    assign grant      = grant_q;
    assign granted_id = granted_id_q;
    assign door_open  = door_open_q;
    assign denied     = denied_q;
    assign state_out  = state_q;

endmodule
